// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
//   Command sequencer wrapped around a registered ALU. It parses byte frames
//   arriving from the UART receiver, loads operands and the function code into
//   the ALU and fires a one-cycle ALU_EN. It then captures the double-width
//   result on ALU_OUT_VALID and returns it to the UART transmitter as two bytes,
//   low byte first, over a valid/ready handshake.
//
//   Frames: CMD_OPER, A, B, FUN     -> load A, B and FUN, then execute
//           CMD_FUN_ONLY, FUN       -> reuse the held A and B, then execute
//
// Ports
//   CLK, RST        clock; asynchronous active-low reset
//   RX_DATA/RX_VALID  received byte plus a one-cycle strobe
//   ALU_A/B/FUN     held operands and function code driven to the ALU
//   ALU_EN          one-cycle execute pulse per operation
//   ALU_OUT/ALU_OUT_VALID  ALU result and its valid flag
//   TX_DATA/TX_VALID/TX_READY  outgoing result bytes (valid/ready handshake)
//   BUSY            high whenever the sequencer is not in IDLE
//   RX_DROP         one-cycle pulse, the cycle after an RX byte is discarded
//                   while the sequencer executes or transmits
//   FRAME_ERR       one-cycle pulse when a partial frame is aborted by timeout
//
// Optional feature
//   CMD_TIMEOUT_EN  when defined, a frame that stalls for TIMEOUT_CYCLES idle
//                   cycles in GET_A/GET_B/GET_FUN is abandoned. When undefined,
//                   the GET states wait indefinitely and FRAME_ERR is tied low.
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          FUNC_WIDTH     = 4,
    parameter logic [7:0]  CMD_OPER       = 8'hCC,
    parameter logic [7:0]  CMD_FUN_ONLY   = 8'hDD,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_DATA,
    input  logic                      RX_VALID,
    output logic [DATA_WIDTH-1:0]     ALU_A,
    output logic [DATA_WIDTH-1:0]     ALU_B,
    output logic [FUNC_WIDTH-1:0]     ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0]     TX_DATA,
    output logic                      TX_VALID,
    input  logic                      TX_READY,
    output logic                      BUSY,
    output logic                      RX_DROP,
    output logic                      FRAME_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_GET_FUN,
        S_ALU_GO, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;

    state_t                    state_reg, state_next;
    logic [DATA_WIDTH-1:0]     alu_a_reg, alu_b_reg;
    logic [FUNC_WIDTH-1:0]     alu_fun_reg;
    logic [2*DATA_WIDTH-1:0]   result_reg;
    logic                      rx_drop_reg;
    logic                      in_get;      // collecting frame bytes
    logic                      in_exec;     // executing or transmitting
    logic                      timeout_hit;
    logic [DATA_WIDTH-1:0]     cmd_oper_w, cmd_fun_only_w;

    // Command constants resized to the RX byte width.
    assign cmd_oper_w     = DATA_WIDTH'(CMD_OPER);
    assign cmd_fun_only_w = DATA_WIDTH'(CMD_FUN_ONLY);

    assign in_get  = (state_reg == S_GET_A) || (state_reg == S_GET_B) ||
                     (state_reg == S_GET_FUN);
    assign in_exec = (state_reg == S_ALU_GO) || (state_reg == S_ALU_WAIT) ||
                     (state_reg == S_TX_LO)  || (state_reg == S_TX_HI);

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_reg;
    logic             frame_err_reg;

    // Counts consecutive idle cycles inside a frame. It is zero on entry to
    // GET_A/GET_FUN (it is held at zero outside the GET states) and restarts
    // on every accepted byte. A byte arriving in the expiry cycle takes
    // priority over the timeout.
    assign timeout_hit = in_get && !RX_VALID &&
                         (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            if (in_get && !RX_VALID && !timeout_hit)
                to_cnt_reg <= to_cnt_reg + CNT_W'(1);
            else
                to_cnt_reg <= '0;
            frame_err_reg <= timeout_hit;
        end
    end

    assign FRAME_ERR = frame_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign FRAME_ERR   = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= S_IDLE;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_fun_reg <= '0;
            result_reg  <= '0;
            rx_drop_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_GET_A && RX_VALID)
                alu_a_reg <= RX_DATA;
            if (state_reg == S_GET_B && RX_VALID)
                alu_b_reg <= RX_DATA;
            if (state_reg == S_GET_FUN && RX_VALID)
                alu_fun_reg <= RX_DATA[FUNC_WIDTH-1:0];
            if (state_reg == S_ALU_WAIT && ALU_OUT_VALID)
                result_reg <= ALU_OUT;
            // Bytes arriving after the frame is complete are discarded.
            rx_drop_reg <= RX_VALID && in_exec;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (RX_VALID && RX_DATA == cmd_oper_w)
                    state_next = S_GET_A;
                else if (RX_VALID && RX_DATA == cmd_fun_only_w)
                    state_next = S_GET_FUN;
            end
            S_GET_A: begin
                if (RX_VALID)         state_next = S_GET_B;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_GET_B: begin
                if (RX_VALID)         state_next = S_GET_FUN;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_GET_FUN: begin
                if (RX_VALID)         state_next = S_ALU_GO;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_ALU_GO:   state_next = S_ALU_WAIT;
            S_ALU_WAIT: if (ALU_OUT_VALID) state_next = S_TX_LO;
            S_TX_LO:    if (TX_READY)      state_next = S_TX_HI;
            S_TX_HI:    if (TX_READY)      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Output logic: every handshake output is decoded from the state alone,
    // so TX_DATA/TX_VALID cannot change while waiting for TX_READY.
    always_comb begin
        ALU_EN   = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = '0;
        case (state_reg)
            S_ALU_GO: ALU_EN = 1'b1;
            S_TX_LO: begin
                TX_VALID = 1'b1;
                TX_DATA  = result_reg[DATA_WIDTH-1:0];
            end
            S_TX_HI: begin
                TX_VALID = 1'b1;
                TX_DATA  = result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign BUSY    = (state_reg != S_IDLE);
    assign RX_DROP = rx_drop_reg;
    assign ALU_A   = alu_a_reg;
    assign ALU_B   = alu_b_reg;
    assign ALU_FUN = alu_fun_reg;

endmodule
